// File: rtl/lane_scroller.sv
// Moves NUM_OBJ objects along one lane at a run-time speed and direction, wrapping
// between the lane bounds, and reports frog/object overlap for ride-along logic.
module lane_scroller #(
  parameter int NUM_OBJ     = 4,
  parameter int X_W         = 10,
  parameter int DIV_W       = 22,
  parameter int OBJ_W       = 32,
  parameter int LEFT_BOUND  = 207,
  parameter int RIGHT_BOUND = 431,
  parameter int LANE_Y      = 182,
  parameter logic [NUM_OBJ*X_W-1:0] INIT_X = '0,
  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic                     restart,
  input  logic                     enable,
  input  logic                     dir,
  input  logic [DIV_W-1:0]         period,
  input  logic [3:0]               step,
  input  logic [X_W-1:0]           frog_x,
  output logic [NUM_OBJ*X_W-1:0]   obj_x,
  output logic [X_W-1:0]           obj_y,
  output logic                     moved,
  output logic signed [X_W:0]      dx,
  output logic                     frog_on,
  output logic [IDX_W-1:0]         frog_idx
);

  localparam int XE = X_W + 1;
  localparam logic [X_W:0]   C_OBJ_W  = XE'(OBJ_W);
  localparam logic [X_W:0]   C_FROG_W = XE'(32);
  localparam logic [X_W:0]   C_LEFT   = XE'(LEFT_BOUND);
  localparam logic [X_W:0]   C_RIGHT  = XE'(RIGHT_BOUND);
  localparam logic [X_W-1:0] C_WRAP_L = X_W'(RIGHT_BOUND);
  localparam logic [X_W-1:0] C_WRAP_R = X_W'(LEFT_BOUND - OBJ_W);

  logic [X_W-1:0]   r_obj_x [NUM_OBJ];
  logic [DIV_W-1:0] r_count;
  logic             r_moved;
  logic [X_W:0]     r_dx;
  logic             r_frog_on;
  logic [IDX_W-1:0] r_frog_idx;

  logic [DIV_W-1:0] w_eff_m1;
  logic             w_tick;
  logic [X_W:0]     w_step_e;
  logic [X_W:0]     w_frog_e;
  logic [X_W-1:0]   w_new [NUM_OBJ];
  logic             w_hit [NUM_OBJ];
  logic             w_any;
  logic [IDX_W-1:0] w_idx;

  // A period of 0 behaves as 1; ">=" lets a lowered period take effect at once.
  assign w_eff_m1 = (period == '0) ? '0 : period - DIV_W'(1);
  assign w_tick   = enable && (r_count >= w_eff_m1);
  assign w_step_e = {{(X_W-3){1'b0}}, step};
  assign w_frog_e = {1'b0, frog_x};

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    logic [X_W:0]   w_ext;
    logic [X_W:0]   w_sum;
    logic [X_W:0]   w_diff;
    logic [X_W-1:0] w_nx;

    assign w_ext  = {1'b0, r_obj_x[g]};
    assign w_sum  = w_ext + w_step_e;
    assign w_diff = w_ext - w_step_e;

    // Widened arithmetic keeps the left-edge test free of underflow.
    always_comb begin
      w_nx = r_obj_x[g];
      if (step != 4'd0) begin
        if (dir) begin
          if (w_sum > C_RIGHT) w_nx = C_WRAP_R;
          else                 w_nx = w_sum[X_W-1:0];
        end else begin
          if (w_ext + C_OBJ_W < C_LEFT + w_step_e) w_nx = C_WRAP_L;
          else                                     w_nx = w_diff[X_W-1:0];
        end
      end
    end

    assign w_new[g] = w_nx;
    assign w_hit[g] = (w_frog_e < w_ext + C_OBJ_W) && (w_ext < w_frog_e + C_FROG_W);
    assign obj_x[g*X_W +: X_W] = r_obj_x[g];
  end

  // Lowest overlapping index wins.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_OBJ; i++) r_obj_x[i] <= INIT_X[i*X_W +: X_W];
      r_count    <= '0;
      r_moved    <= 1'b0;
      r_dx       <= '0;
      r_frog_on  <= 1'b0;
      r_frog_idx <= '0;
    end else if (restart) begin
      for (int i = 0; i < NUM_OBJ; i++) r_obj_x[i] <= INIT_X[i*X_W +: X_W];
      r_count    <= '0;
      r_moved    <= 1'b0;
      r_dx       <= '0;
      r_frog_on  <= 1'b0;
      r_frog_idx <= '0;
    end else begin
      r_frog_on  <= w_any;
      r_frog_idx <= w_idx;
      if (w_tick) begin
        for (int i = 0; i < NUM_OBJ; i++) r_obj_x[i] <= w_new[i];
        r_count <= '0;
        r_moved <= 1'b1;
        r_dx    <= dir ? w_step_e : -w_step_e;
      end else begin
        r_moved <= 1'b0;
        if (enable) r_count <= r_count + DIV_W'(1);
      end
    end
  end

  assign obj_y    = X_W'(LANE_Y);
  assign moved    = r_moved;
  assign dx       = $signed(r_dx);
  assign frog_on  = r_frog_on;
  assign frog_idx = r_frog_idx;

endmodule

// File: tb/tb_lane_scroller.sv
// Randomised and directed stimulus for lane_scroller, checked every cycle against
// an integer model of the lane rules.
module tb_lane_scroller;

  logic        frame_clk;
  logic        Reset;
  logic        restart;
  logic        enable;
  logic        dir;
  logic [21:0] period;
  logic [3:0]  step;
  logic [9:0]  frog_x;
  logic [39:0] obj_x;
  logic [9:0]  obj_y;
  logic        moved;
  logic signed [10:0] dx;
  logic        frog_on;
  logic [1:0]  frog_idx;

  lane_scroller #(
    .INIT_X({10'd310, 10'd210, 10'd110, 10'd10})
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .restart(restart), .enable(enable),
    .dir(dir), .period(period), .step(step), .frog_x(frog_x),
    .obj_x(obj_x), .obj_y(obj_y), .moved(moved), .dx(dx),
    .frog_on(frog_on), .frog_idx(frog_idx)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int m_x [4];
  int m_cnt, m_moved, m_dx, m_on, m_idx;
  int init_x [4] = '{10, 110, 210, 310};

  task automatic chk(input string tag, input integer obs, input integer exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_x[i] = init_x[i];
    m_cnt = 0; m_moved = 0; m_dx = 0; m_on = 0; m_idx = 0;
  endfunction

  function automatic int eff_period();
    return (period == 0) ? 1 : int'(period);
  endfunction

  function automatic bit tick_due();
    return enable && (m_cnt >= eff_period() - 1);
  endfunction

  // Applies one clock edge of lane rules using the inputs present at that edge.
  function automatic void model_step();
    int on, idx, s, f;
    if (restart) begin
      model_reset();
      return;
    end
    on = 0; idx = 0; f = int'(frog_x);
    for (int i = 0; i < 4; i++)
      if (on == 0 && f < m_x[i] + 32 && m_x[i] < f + 32) begin
        on = 1; idx = i;
      end
    if (tick_due()) begin
      s = int'(step);
      m_cnt = 0; m_moved = 1;
      m_dx = dir ? s : -s;
      if (s != 0)
        for (int i = 0; i < 4; i++) begin
          if (dir) m_x[i] = (m_x[i] + s > 431) ? 175 : m_x[i] + s;
          else     m_x[i] = (m_x[i] + 32 < 207 + s) ? 431 : m_x[i] - s;
        end
    end else begin
      m_moved = 0;
      if (enable) m_cnt++;
    end
    m_on = on; m_idx = idx;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s.obj_x%0d", tag, i), integer'(obj_x[i*10 +: 10]), m_x[i]);
    chk({tag, ".obj_y"}, integer'(obj_y), 182);
    chk({tag, ".moved"}, integer'(moved), m_moved);
    chk({tag, ".dx"}, integer'(dx), m_dx);
    chk({tag, ".frog_on"}, integer'(frog_on), m_on);
    chk({tag, ".frog_idx"}, integer'(frog_idx), m_idx);
  endtask

  task automatic cycle(input string tag);
    @(posedge frame_clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  int n_moves;
  int f;

  initial begin
    Reset = 1'b1; restart = 1'b0; enable = 1'b0; dir = 1'b0;
    period = 22'd1; step = 4'd0; frog_x = 10'd0;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    check_all("reset");
    @(negedge frame_clk);
    Reset = 1'b0;

    // Period 3, step 1, moving left: pulse every third cycle
    period = 22'd3; step = 4'd1; dir = 1'b0; enable = 1'b1;
    n_moves = 0;
    for (int i = 0; i < 9; i++) begin
      cycle("period3");
      n_moves += int'(moved);
    end
    chk("period3.pulses", n_moves, 3);
    chk("period3.obj3", integer'(obj_x[39:30]), 307);

    // Step 1 sweeps visit every lane position in both directions, hitting both wrap edges
    period = 22'd1;
    for (int i = 0; i < 300; i++) cycle("sweep_left");
    dir = 1'b1;
    for (int i = 0; i < 300; i++) cycle("sweep_right");

    // Zero step still pulses but nothing moves
    step = 4'd0;
    for (int i = 0; i < 10; i++) cycle("step0");

    // Pause: counter and positions frozen, frog tracking continues
    period = 22'd4; step = 4'd5;
    repeat (2) cycle("pre_pause");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      frog_x = 10'($urandom_range(180, 460));
      cycle("pause");
    end
    enable = 1'b1;

    // Restart collides with a tick and must win
    for (int i = 0; i < 8 && !tick_due(); i++) cycle("to_tick");
    chk("restart.tick_due", integer'(tick_due()), 1);
    restart = 1'b1;
    cycle("restart_on_tick");
    restart = 1'b0;

    // Frog overlap edges against object 2, with the lane paused
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int offs [4] = '{31, 32, -31, -32};
      f = m_x[2] + offs[k];
      if (f < 0) f = 0;
      frog_x = 10'(f);
      cycle($sformatf("frog_edge%0d", k));
      cycle($sformatf("frog_edge%0d_hold", k));
    end
    enable = 1'b1;

    // Asynchronous reset between edges
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge frame_clk);
    Reset = 1'b0;

    // Random traffic: speed, direction, pause, restart, frog position
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) period = 22'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0)  step   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) dir    = 1'($urandom_range(0, 1));
      frog_x = 10'($urandom_range(150, 480));
      cycle("random");
    end
    restart = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
